alu_req_engine: RTL and testbench
=================================

ALU_REQ_ENGINE -- requirements
Module: alu_req_engine

Interface
REQ-001 Parameter NUM_BITS, default 8, SHALL set operand/result width (legal range 4..32).
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  engine accepts a request this cycle.
REQ-006 req_a, req_b  input  NUM_BITS each  operands.
REQ-007 req_signed  input  1  1 = two's-complement operands.
REQ-008 req_opcode  input  4  operation code (see REQ-012).
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  consumer takes the response.
REQ-011 rsp_result  output  NUM_BITS; rsp_z, rsp_n, rsp_c, rsp_v  output  1 each; rsp_err  output  1  illegal opcode.

Function
REQ-012 Opcodes: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 xor, 0111 nor, 1000 not A, 1001 A>B, 1010 A<B, 1100 lsl-by-1, 1101 lsr-by-1, 1110 asr-by-1; 1011 and 1111 illegal.
REQ-013 Transfer occurs on a rising edge with valid&ready high; req_* SHALL be captured into internal registers at acceptance.
REQ-014 States: IDLE, DIV, RESP; req_ready SHALL equal (state==IDLE); no request overlap.
REQ-015 IDLE: on acceptance of div with b!=0 and no signed overflow -> DIV; any other accepted opcode -> RESP; no acceptance -> stay.
REQ-016 Non-div ops, div-by-zero, signed overflow div and illegal ops SHALL reach rsp_valid=1 one cycle after acceptance, with result/flags computed by the combinational ALU instance from registered operands.
REQ-017 DIV: restoring divider on operand magnitudes, one quotient bit per cycle, exactly NUM_BITS cycles, then RESP; rsp_valid SHALL rise NUM_BITS+1 cycles after acceptance.
REQ-018 Signed div: quotient truncates toward zero; negated when operand signs differ; remainder discarded.
REQ-019 Div flags: Z = (result==0); N = req_signed & result[MSB]; C = 0; V = 0.
REQ-020 Div-by-zero (b==0) SHALL give result 0, Z=1, N=0, C=0, V=1, in any signedness.
REQ-021 Signed overflow (a = most-negative, b = -1) SHALL give result 0, Z=1, N=0, C=0, V=1.
REQ-022 Non-div flag rules SHALL be those of the ALU instance (add/sub carry = unsigned carry/borrow, V = signed overflow in signed mode, comparisons return 1/0, shifts set C to the bit shifted out).
REQ-023 Illegal opcode: result 0, Z=1, N=C=V=0, rsp_err=1; rsp_err=0 for all legal opcodes.
REQ-024 RESP: rsp_valid=1 with all rsp_* stable until rsp_ready sampled high; then -> IDLE; new request accepted no earlier than the following cycle.
REQ-025 rsp_ready high while rsp_valid low SHALL have no effect; req_valid while not ready SHALL be ignored, never queued.
REQ-026 Outputs rsp_* SHALL be registered (no combinational path from req_* to rsp_*).

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, rsp_valid=0, rsp_result=0, all flags and rsp_err=0, divider registers=0; req_ready=1 after release.
REQ-028 Reset during DIV or RESP SHALL discard the operation; no response SHALL appear after release.

Structure
REQ-029 Shared package alu_pkg SHALL hold the opcode constants, the state enumeration and the illegal-opcode list.
REQ-030 One sub-module: the existing combinational ALU (parameter NUM_BITS, ports A, B, signed_mode, opcode, Result, Z, N, C, V), instantiated once; divider logic local to alu_req_engine.

Verification
REQ-031 NUM_BITS=8, add 255+1 unsigned, rsp_ready=1 -> one cycle later result 0, Z=1, C=1, V=0, err=0.
REQ-032 Unsigned div 200/7 -> rsp_valid exactly 9 cycles after acceptance, result 28, Z=N=C=V=0; signed div -100/7 -> result -14 (242), N=1.
REQ-033 Div 255/0 unsigned and signed div 128/255 -> one cycle later result 0, Z=1, V=1.
REQ-034 Response held with rsp_ready=0 for 5 cycles -> rsp_* unchanged, req_ready=0; rsp_ready=1 -> IDLE next cycle, back-to-back request accepted.
REQ-035 Opcode 1011 -> result 0, Z=1, rsp_err=1; rst_n pulsed low mid-DIV (cycle 4) -> rsp_valid stays 0, req_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request engine.
// Holds the opcode encodings, the engine state encoding and the illegal-opcode list.
// No ports: this is a package.
package alu_pkg;

  // Opcode encodings
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_GT  = 4'b1001;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_LSL = 4'b1100;
  localparam logic [3:0] OP_LSR = 4'b1101;
  localparam logic [3:0] OP_ASR = 4'b1110;

  // Illegal-opcode list
  localparam logic [3:0] OP_ILLEGAL_A = 4'b1011;
  localparam logic [3:0] OP_ILLEGAL_B = 4'b1111;

  // Engine states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == OP_ILLEGAL_A) || (op == OP_ILLEGAL_B);
  endfunction

endpackage

// File: rtl/alu_req_engine_alu.sv
// Combinational ALU used by the request engine.
// Ports:
//   A, B         operands (NUM_BITS)
//   signed_mode  1 = two's-complement operands
//   opcode       operation code (alu_pkg OP_*)
//   Result       result (NUM_BITS)
//   Z, N, C, V   zero, negative (signed mode only), carry/borrow/shift-out, signed overflow
// Division is done by the sequential divider in the engine; for OP_DIV this block only
// produces the exception response (result 0, V=1), which the engine uses for b==0 and
// signed overflow. Illegal opcodes give result 0 with only Z set.
module alu_req_engine_alu
  import alu_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0] A,
  input  logic [NUM_BITS-1:0] B,
  input  logic                signed_mode,
  input  logic [3:0]          opcode,
  output logic [NUM_BITS-1:0] Result,
  output logic                Z,
  output logic                N,
  output logic                C,
  output logic                V
);

  localparam int MSB = NUM_BITS - 1;

  logic [2*NUM_BITS-1:0] w_a_ext;
  logic [2*NUM_BITS-1:0] w_b_ext;
  logic [2*NUM_BITS-1:0] w_prod;
  logic [NUM_BITS:0]     w_sum;
  logic [NUM_BITS:0]     w_diff;
  logic                  w_gt;
  logic                  w_lt;

  always_comb begin
    // Extension by signedness lets one multiplier serve both modes: the low 2N bits of the
    // product are exact either way.
    w_a_ext = signed_mode ? {{NUM_BITS{A[MSB]}}, A} : {{NUM_BITS{1'b0}}, A};
    w_b_ext = signed_mode ? {{NUM_BITS{B[MSB]}}, B} : {{NUM_BITS{1'b0}}, B};
    w_prod  = w_a_ext * w_b_ext;
    w_sum   = {1'b0, A} + {1'b0, B};
    w_diff  = {1'b0, A} - {1'b0, B};
    w_gt    = signed_mode ? ($signed(A) > $signed(B)) : (A > B);
    w_lt    = signed_mode ? ($signed(A) < $signed(B)) : (A < B);

    Result = '0;
    C      = 1'b0;
    V      = 1'b0;
    case (opcode)
      OP_ADD: begin
        Result = w_sum[MSB:0];
        C      = w_sum[NUM_BITS];
        V      = signed_mode & (A[MSB] == B[MSB]) & (w_sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        Result = w_diff[MSB:0];
        C      = w_diff[NUM_BITS];  // borrow
        V      = signed_mode & (A[MSB] != B[MSB]) & (w_diff[MSB] != A[MSB]);
      end
      OP_MUL: begin
        Result = w_prod[MSB:0];
        // Overflow when the upper half is not the extension of the truncated result
        V      = w_prod[2*NUM_BITS-1:NUM_BITS] != {NUM_BITS{signed_mode & w_prod[MSB]}};
      end
      OP_DIV: V = 1'b1;
      OP_AND: Result = A & B;
      OP_OR:  Result = A | B;
      OP_XOR: Result = A ^ B;
      OP_NOR: Result = ~(A | B);
      OP_NOT: Result = ~A;
      OP_GT:  Result = {{(NUM_BITS-1){1'b0}}, w_gt};
      OP_LT:  Result = {{(NUM_BITS-1){1'b0}}, w_lt};
      OP_LSL: begin
        Result = {A[MSB-1:0], 1'b0};
        C      = A[MSB];
      end
      OP_LSR: begin
        Result = {1'b0, A[MSB:1]};
        C      = A[0];
      end
      OP_ASR: begin
        Result = {A[MSB], A[MSB:1]};
        C      = A[0];
      end
      default: ;
    endcase
    Z = (Result == '0);
    N = signed_mode & Result[MSB];
  end

endmodule

// File: rtl/alu_req_engine.sv
// Request/response wrapper around the combinational ALU with a multi-cycle divider.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   req_a, req_b, req_signed    operands and signedness
//   req_opcode                  operation code
//   rsp_valid / rsp_ready       response handshake
//   rsp_result, rsp_z/n/c/v     registered result and flags
//   rsp_err                     illegal opcode
// Division (b != 0, no signed overflow) runs a restoring divider on operand magnitudes,
// one quotient bit per cycle; every other operation is taken from the ALU instance.
module alu_req_engine
  import alu_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [NUM_BITS-1:0] req_a,
  input  logic [NUM_BITS-1:0] req_b,
  input  logic                req_signed,
  input  logic [3:0]          req_opcode,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NUM_BITS-1:0] rsp_result,
  output logic                rsp_z,
  output logic                rsp_n,
  output logic                rsp_c,
  output logic                rsp_v,
  output logic                rsp_err
);

  localparam int                   MSB      = NUM_BITS - 1;
  localparam int                   CNT_W    = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(NUM_BITS - 1);
  localparam logic [NUM_BITS-1:0]  MOST_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};

  logic [1:0]          r_state;
  logic [1:0]          w_state_d;
  logic [NUM_BITS-1:0] r_a;
  logic [NUM_BITS-1:0] r_b;
  logic                r_signed;
  logic [3:0]          r_op;

  // Divider: r_quo starts as the dividend magnitude and is shifted into the quotient
  logic [NUM_BITS-1:0] r_quo;
  logic [NUM_BITS-1:0] r_rem;
  logic [NUM_BITS-1:0] r_den;
  logic [CNT_W-1:0]    r_cnt;

  logic                r_rsp_valid;
  logic [NUM_BITS-1:0] r_rsp_result;
  logic                r_rsp_z;
  logic                r_rsp_n;
  logic                r_rsp_c;
  logic                r_rsp_v;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_req_div_ok;
  logic [NUM_BITS-1:0] w_mag_a;
  logic [NUM_BITS-1:0] w_mag_b;
  logic [NUM_BITS:0]   w_shift;
  logic [NUM_BITS:0]   w_trial;
  logic                w_fit;
  logic [NUM_BITS-1:0] w_rem_next;
  logic                w_div_exc;
  logic                w_use_div;
  logic [NUM_BITS-1:0] w_div_result;

  logic [NUM_BITS-1:0] w_alu_result;
  logic                w_alu_z;
  logic                w_alu_n;
  logic                w_alu_c;
  logic                w_alu_v;

  alu_req_engine_alu #(
    .NUM_BITS (NUM_BITS)
  ) u_alu (
    .A           (r_a),
    .B           (r_b),
    .signed_mode (r_signed),
    .opcode      (r_op),
    .Result      (w_alu_result),
    .Z           (w_alu_z),
    .N           (w_alu_n),
    .C           (w_alu_c),
    .V           (w_alu_v)
  );

  assign w_accept     = req_valid & (r_state == ST_IDLE);
  assign w_req_div_ok = (req_opcode == OP_DIV) && (req_b != '0) &&
                        !(req_signed && (req_a == MOST_NEG) && (req_b == '1));
  assign w_mag_a      = (req_signed && req_a[MSB]) ? -req_a : req_a;
  assign w_mag_b      = (req_signed && req_b[MSB]) ? -req_b : req_b;

  // One restoring step: a borrow out of the trial subtraction means the divisor did not fit
  assign w_shift      = {r_rem, r_quo[MSB]};
  assign w_trial      = w_shift - {1'b0, r_den};
  assign w_fit        = ~w_trial[NUM_BITS];
  assign w_rem_next   = w_fit ? w_trial[MSB:0] : w_shift[MSB:0];

  assign w_div_exc    = (r_b == '0) || (r_signed && (r_a == MOST_NEG) && (r_b == '1));
  assign w_use_div    = (r_op == OP_DIV) && !w_div_exc;
  assign w_div_result = (r_signed && (r_a[MSB] ^ r_b[MSB])) ? -r_quo : r_quo;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_d = w_req_div_ok ? ST_DIV : ST_RESP;
      ST_DIV:  if (r_cnt == CNT_LAST) w_state_d = ST_RESP;
      ST_RESP: if (r_rsp_valid && rsp_ready) w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_signed     <= 1'b0;
      r_op         <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_den        <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_z      <= 1'b0;
      r_rsp_n      <= 1'b0;
      r_rsp_c      <= 1'b0;
      r_rsp_v      <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_state_d;

      if (w_accept) begin
        r_a      <= req_a;
        r_b      <= req_b;
        r_signed <= req_signed;
        r_op     <= req_opcode;
        r_quo    <= w_mag_a;
        r_den    <= w_mag_b;
        r_rem    <= '0;
        r_cnt    <= '0;
      end else if (r_state == ST_DIV) begin
        r_quo <= {r_quo[MSB-1:0], w_fit};
        r_rem <= w_rem_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // First RESP cycle loads the output registers; they then hold until consumed.
      if (r_state == ST_RESP) begin
        if (!r_rsp_valid) begin
          r_rsp_valid <= 1'b1;
          if (w_use_div) begin
            r_rsp_result <= w_div_result;
            r_rsp_z      <= (w_div_result == '0);
            r_rsp_n      <= r_signed & w_div_result[MSB];
            r_rsp_c      <= 1'b0;
            r_rsp_v      <= 1'b0;
            r_rsp_err    <= 1'b0;
          end else begin
            r_rsp_result <= w_alu_result;
            r_rsp_z      <= w_alu_z;
            r_rsp_n      <= w_alu_n;
            r_rsp_c      <= w_alu_c;
            r_rsp_v      <= w_alu_v;
            r_rsp_err    <= is_illegal_op(r_op);
          end
        end else if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
        end
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_z      = r_rsp_z;
  assign rsp_n      = r_rsp_n;
  assign rsp_c      = r_rsp_c;
  assign rsp_v      = r_rsp_v;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_req_engine.sv
// Self-checking bench for alu_req_engine (NUM_BITS = 8): directed vector table plus
// hand-written sequences for response hold, back-to-back issue and reset mid-operation.
module tb_alu_req_engine;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [NB-1:0] req_a;
  logic [NB-1:0] req_b;
  logic          req_signed;
  logic [3:0]    req_opcode;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [NB-1:0] rsp_result;
  logic          rsp_z, rsp_n, rsp_c, rsp_v, rsp_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_req_engine #(
    .NUM_BITS (NB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n),
    .rsp_c      (rsp_c),
    .rsp_v      (rsp_v),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          s;
    logic [3:0]    op;
    logic [NB-1:0] res;
    logic [4:0]    flg;  // {z, n, c, v, err}
    int            lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_v(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic s,
                       input logic [3:0] op, input logic [NB-1:0] res, input logic [4:0] flg,
                       input int lat);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.op = op; v.res = res; v.flg = flg; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [4:0] flags();
    return {rsp_z, rsp_n, rsp_c, rsp_v, rsp_err};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input string name, input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic s, input logic [3:0] op);
    bit ok;
    req_a = a; req_b = b; req_signed = s; req_opcode = op; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_accept"}, {31'd0, ok}, 32'd1);
    if (ok) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  ok;

    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_signed = 1'b0;
    req_opcode = '0; rsp_ready = 1'b1;

    //           a       b      s     op       res     {z n c v e}  lat
    add_v(8'd255, 8'd1,   1'b0, 4'b0000, 8'd0,   5'b10100, 1);
    add_v(8'd100, 8'd50,  1'b1, 4'b0000, 8'd150, 5'b01010, 1);
    add_v(8'd5,   8'd7,   1'b0, 4'b0001, 8'd254, 5'b00100, 1);
    add_v(8'd128, 8'd1,   1'b1, 4'b0001, 8'd127, 5'b00010, 1);
    add_v(8'd16,  8'd17,  1'b0, 4'b0010, 8'd16,  5'b00010, 1);
    add_v(8'd253, 8'd5,   1'b1, 4'b0010, 8'd241, 5'b01000, 1);
    add_v(8'd200, 8'd7,   1'b0, 4'b0011, 8'd28,  5'b00000, 9);
    add_v(8'd156, 8'd7,   1'b1, 4'b0011, 8'd242, 5'b01000, 9);  // -100/7 = -14
    add_v(8'd7,   8'd254, 1'b1, 4'b0011, 8'd253, 5'b01000, 9);  // 7/-2 = -3
    add_v(8'd249, 8'd254, 1'b1, 4'b0011, 8'd3,   5'b00000, 9);  // -7/-2 = 3
    add_v(8'd0,   8'd5,   1'b1, 4'b0011, 8'd0,   5'b10000, 9);
    add_v(8'd255, 8'd0,   1'b0, 4'b0011, 8'd0,   5'b10010, 1);
    add_v(8'd128, 8'd255, 1'b1, 4'b0011, 8'd0,   5'b10010, 1);  // -128/-1 overflow
    add_v(8'd5,   8'd0,   1'b1, 4'b0011, 8'd0,   5'b10010, 1);
    add_v(8'hF0,  8'h3C,  1'b0, 4'b0100, 8'h30,  5'b00000, 1);
    add_v(8'hF0,  8'h0F,  1'b0, 4'b0101, 8'hFF,  5'b00000, 1);
    add_v(8'hAA,  8'hAA,  1'b0, 4'b0110, 8'h00,  5'b10000, 1);
    add_v(8'hF0,  8'h0F,  1'b0, 4'b0111, 8'h00,  5'b10000, 1);
    add_v(8'h0F,  8'h00,  1'b1, 4'b1000, 8'hF0,  5'b01000, 1);
    add_v(8'h01,  8'hFF,  1'b1, 4'b1001, 8'd1,   5'b00000, 1);
    add_v(8'h01,  8'hFF,  1'b0, 4'b1001, 8'd0,   5'b10000, 1);
    add_v(8'd3,   8'd9,   1'b0, 4'b1010, 8'd1,   5'b00000, 1);
    add_v(8'h81,  8'h00,  1'b0, 4'b1100, 8'h02,  5'b00100, 1);
    add_v(8'h81,  8'h00,  1'b0, 4'b1101, 8'h40,  5'b00100, 1);
    add_v(8'h82,  8'h00,  1'b1, 4'b1110, 8'hC1,  5'b01000, 1);
    add_v(8'd12,  8'd34,  1'b0, 4'b1011, 8'd0,   5'b10001, 1);
    add_v(8'd12,  8'd34,  1'b1, 4'b1111, 8'd0,   5'b10001, 1);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_result", {24'd0, rsp_result}, 32'd0);
    check("rst_flags", {27'd0, flags()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Rising rsp_ready with no response pending does nothing
    repeat (3) @(negedge clk);
    check("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);

    foreach (vecs[i]) begin
      issue($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].op);
      wait_rsp(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_res", i), {24'd0, rsp_result}, {24'd0, vecs[i].res});
      check($sformatf("v%0d_flags", i), {27'd0, flags()}, {27'd0, vecs[i].flg});
      @(negedge clk);
    end
    check("consumed", {31'd0, rsp_valid}, 32'd0);

    // Hold with rsp_ready low; a request offered meanwhile must be ignored
    rsp_ready = 1'b0;
    issue("hold", 8'd3, 8'd4, 1'b0, 4'b0000);
    wait_rsp(lat);
    check("hold_lat", lat, 1);
    req_a = 8'd100; req_b = 8'd100; req_signed = 1'b0; req_opcode = 4'b0000;
    req_valid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== 8'd7 || flags() !== 5'b00000 ||
          req_ready !== 1'b0) ok = 1'b0;
    end
    check("hold_stable", {31'd0, ok}, 32'd1);
    req_a = 8'd9; req_b = 8'd4; req_opcode = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("b2b_ready", {31'd0, req_ready}, 32'd1);
    check("b2b_valid_low", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("b2b_lat", lat, 1);
    check("b2b_res", {24'd0, rsp_result}, 32'd5);
    @(negedge clk);

    // Reset during DIV (fourth cycle)
    issue("rdiv", 8'd200, 8'd7, 1'b0, 4'b0011);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rdiv_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
    end
    check("rdiv_quiet", {31'd0, ok}, 32'd1);

    // Reset while a response is held
    rsp_ready = 1'b0;
    issue("rresp", 8'd5, 8'd6, 1'b0, 4'b0000);
    wait_rsp(lat);
    check("rresp_res", {24'd0, rsp_result}, 32'd11);
    rst_n = 1'b0;
    #1;
    check("rresp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rresp_result", {24'd0, rsp_result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) ok = 1'b0;
    end
    check("rresp_quiet", {31'd0, ok}, 32'd1);

    // Engine still works after reset
    issue("post", 8'd1, 8'd2, 1'b0, 4'b0000);
    wait_rsp(lat);
    check("post_lat", lat, 1);
    check("post_res", {24'd0, rsp_result}, 32'd3);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
